// File: rtl/window_conv_if.sv
// AXI4-Stream interface bundle shared by the video pipeline blocks.
//   tvalid/tready : handshake
//   tdata         : payload, DATA_WIDTH bits
//   tlast         : end of line
//   tuser         : start of frame
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/window_conv.sv
// window_conv: per-component signed 2D convolution over a WIN_SIZE x WIN_SIZE
// window stream, followed by rounding, arithmetic normalisation and clamping.
// Three-stage pipeline (multiply, sum, normalise) with a single shared enable.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   coef_i       : signed kernel, tap (y,x) at [(y*WIN_SIZE+x+1)*COEF_WIDTH-1 -: COEF_WIDTH]
//   window_i     : input windows; tuser = first window of frame, tlast = last of line
//   video_o      : filtered pixels in tdata[PX_WIDTH-1:0], upper bits zero
module window_conv #(
  parameter int PX_WIDTH        = 30,
  parameter int COMP_WIDTH      = 10,
  parameter int WIN_SIZE        = 3,
  parameter int COEF_WIDTH      = 8,
  parameter int FRAC_BITS       = 4,
  parameter int WIN_TDATA_WIDTH = 272,
  parameter int TDATA_WIDTH     = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0] coef_i,
  axi4_stream_if.slave                          window_i,
  axi4_stream_if.master                         video_o
);

  localparam int COMP_NUM  = PX_WIDTH / COMP_WIDTH;
  localparam int TAPS      = WIN_SIZE * WIN_SIZE;
  localparam int CENTER    = TAPS / 2;
  localparam int KW        = TAPS * COEF_WIDTH;
  localparam int PW        = COMP_WIDTH + 1 + COEF_WIDTH;
  localparam int SW        = PW + $clog2(TAPS);
  localparam int ROUND_INT = (FRAC_BITS > 0) ? (1 << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : 0;

  localparam logic signed [SW:0] RND  = (SW+1)'(ROUND_INT);
  localparam logic signed [SW:0] MAXV = (SW+1)'((1 << COMP_WIDTH) - 1);

  function automatic logic [KW-1:0] identity_kernel();
    logic [KW-1:0] k;
    k = '0;
    k[CENTER*COEF_WIDTH +: COEF_WIDTH] = COEF_WIDTH'(1 << FRAC_BITS);
    return k;
  endfunction

  // Round half up, arithmetic shift, then clamp to the unsigned component range.
  function automatic logic [COMP_WIDTH-1:0] norm_sat(input logic signed [SW-1:0] s);
    logic signed [SW:0]    t;
    logic [COMP_WIDTH-1:0] r;
    t = $signed({s[SW-1], s}) + RND;
    t = t >>> FRAC_BITS;
    if (t[SW])         r = '0;
    else if (t > MAXV) r = '1;
    else               r = t[COMP_WIDTH-1:0];
    return r;
  endfunction

  logic          adv;
  logic          accept;
  logic          load;
  logic [KW-1:0] kern_q;
  logic [KW-1:0] kern_eff;

  logic signed [PW-1:0] prod_d  [COMP_NUM][TAPS];
  logic signed [PW-1:0] prod_p1 [COMP_NUM][TAPS];
  logic signed [SW-1:0] sum_d   [COMP_NUM];
  logic signed [SW-1:0] sum_p2  [COMP_NUM];
  logic [TDATA_WIDTH-1:0] tdata_d;
  logic [TDATA_WIDTH-1:0] tdata_p3;

  logic vld_p1, vld_p2, vld_p3;
  logic last_p1, last_p2, last_p3;
  logic user_p1, user_p2, user_p3;

  assign adv             = !vld_p3 || video_o.tready;
  assign window_i.tready = adv;
  assign accept          = window_i.tvalid && adv;
  // A start-of-frame beat uses the kernel it brings with it.
  assign load            = accept && window_i.tuser;
  assign kern_eff        = load ? coef_i : kern_q;

  assign video_o.tvalid = vld_p3;
  assign video_o.tdata  = tdata_p3;
  assign video_o.tlast  = last_p3;
  assign video_o.tuser  = user_p3;

  if (WIN_TDATA_WIDTH > TAPS*PX_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^window_i.tdata[WIN_TDATA_WIDTH-1:TAPS*PX_WIDTH];
  end

  always_comb begin
    for (int c = 0; c < COMP_NUM; c++) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_d[c][t] = PW'($signed({1'b0, window_i.tdata[t*PX_WIDTH + c*COMP_WIDTH +: COMP_WIDTH]}))
                     * PW'($signed(kern_eff[t*COEF_WIDTH +: COEF_WIDTH]));
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COMP_NUM; c++) begin
      sum_d[c] = '0;
      for (int t = 0; t < TAPS; t++) begin
        sum_d[c] = sum_d[c] + SW'(prod_p1[c][t]);
      end
    end
  end

  always_comb begin
    tdata_d = '0;
    for (int c = 0; c < COMP_NUM; c++) begin
      tdata_d[c*COMP_WIDTH +: COMP_WIDTH] = norm_sat(sum_p2[c]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kern_q   <= identity_kernel();
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      last_p1  <= 1'b0;
      last_p2  <= 1'b0;
      last_p3  <= 1'b0;
      user_p1  <= 1'b0;
      user_p2  <= 1'b0;
      user_p3  <= 1'b0;
      tdata_p3 <= '0;
    end else if (adv) begin
      if (load) kern_q <= coef_i;
      // S1 -> S2 -> S3 sideband, bubbles pass through as vld = 0
      vld_p1   <= window_i.tvalid;
      last_p1  <= window_i.tlast;
      user_p1  <= window_i.tuser;
      vld_p2   <= vld_p1;
      last_p2  <= last_p1;
      user_p2  <= user_p1;
      vld_p3   <= vld_p2;
      last_p3  <= last_p2;
      user_p3  <= user_p2;
      // S3: normalised, clamped output pixel
      tdata_p3 <= tdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      // S1: per-tap products
      prod_p1 <= prod_d;
      // S2: full-precision sums
      sum_p2  <= sum_d;
    end
  end

endmodule

// File: doc/window_conv.md
Name: window_conv

Overview:
- Consumes the WIN_SIZE x WIN_SIZE window stream produced by the line-buffer/window stage.
- Produces one filtered pixel per accepted window via per-component signed 2D convolution, rounding, arithmetic normalisation and saturation.
- Output is a standard video AXI4-Stream feeding the downstream video pipeline.
- Kernel coefficients are frame-synchronous: they update only on start-of-frame.

Parameters:
- PX_WIDTH, 30: packed pixel width.
- COMP_WIDTH, 10: component width. COMP_NUM = PX_WIDTH / COMP_WIDTH; PX_WIDTH must be a multiple of COMP_WIDTH.
- WIN_SIZE, 3: window side, odd, 3..7.
- COEF_WIDTH, 8: signed coefficient width.
- FRAC_BITS, 4: fractional bits of the coefficients.
- WIN_TDATA_WIDTH, 272: window_i tdata width, at least WIN_SIZE*WIN_SIZE*PX_WIDTH, byte-multiple.
- TDATA_WIDTH, 32: video_o tdata width, at least PX_WIDTH, byte-multiple.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- coef_i  in  WIN_SIZE*WIN_SIZE*COEF_WIDTH  signed kernel. Coefficient (y,x) is at bits [(y*WIN_SIZE+x+1)*COEF_WIDTH-1 -: COEF_WIDTH].
- window_i  axi4_stream_if.slave  WIN_TDATA_WIDTH  window stream. Pixel (y,x) is at [(y*WIN_SIZE+x+1)*PX_WIDTH-1 -: PX_WIDTH]. tuser marks the first window of a frame; tlast marks the last window of a line.
- video_o  axi4_stream_if.master  TDATA_WIDTH  filtered pixels in [PX_WIDTH-1:0]; upper bits are 0.

Interface note:
- Reset rst_i, asynchronous, active-high; clock clk_i.

Behaviour:
- Reset values:
  - video_o tvalid/tdata/tlast/tuser = 0.
  - All pipeline valids = 0.
  - Active kernel = identity: centre coefficient = 1<<FRAC_BITS, all others 0.
- Pipeline enable: adv = !video_o.tvalid || video_o.tready.
  - window_i.tready = adv.
  - All stages move together when adv = 1 and hold otherwise. Data and sideband never change while stalled.
  - Bubbles (valid = 0) propagate as bubbles.
- Pipeline stages (latency 3 cycles from accepted beat to video_o.tvalid, with no backpressure):
  - S1 (multiply): per component c and tap (y,x), product = signed({1'b0, pix}) * coef. Product width PW = COMP_WIDTH+1+COEF_WIDTH. The active kernel is used.
  - S2 (sum): full-precision sum per component, width PW + clog2(WIN_SIZE*WIN_SIZE). No overflow is possible.
  - S3 (normalise): res = (sum + (1<<(FRAC_BITS-1))) >>> FRAC_BITS, arithmetic shift. For FRAC_BITS = 0 no rounding term is added. Clamp to [0, 2^COMP_WIDTH-1]. Write to video_o.tdata component c.
- Sideband: tlast and tuser travel with their beat, unmodified, through all 3 stages.
- Kernel update:
  - When a beat is accepted (window_i.tvalid && window_i.tready) with tuser = 1, coef_i is latched into the active kernel in that cycle.
  - That same beat and all following beats use the new kernel.
  - coef_i changes at any other time have no effect.
  - A stalled tuser beat (tready = 0) does not latch.
- Beats already in flight keep their original products. There is no retroactive recompute.
- Reset mid-stream flushes all stages, drops in-flight beats and restores the identity kernel.
- Throughput: 1 pixel/cycle when video_o.tready is held at 1.
- No frame or line bookkeeping: the block is purely per-beat. Line and frame structure is carried only by tlast/tuser.

Test Plan:
- Identity after reset, WIN_SIZE=3, centre pixel 0x1234567 in every window, tready=1 → video_o.tdata[29:0] = 0x1234567 exactly 3 cycles after acceptance; tvalid=1 for 1 cycle per beat.
- Box-blur kernel, all coefficients 1, FRAC_BITS=4, every component of all 9 pixels = 16, loaded with a tuser=1 beat → each component out = (144+8)>>4 = 9; this applies to the tuser beat itself.
- Saturation:
  - All coefficients +127, all components 1023 → each component 1023.
  - Centre coefficient -16, others 0, any nonzero pixel → each component 0.
- Backpressure: 10-beat line with tlast on beat 9, video_o.tready toggled pseudo-randomly → all 10 outputs in order, values match the model, tlast only on the 10th, no drops or duplicates, tdata stable while tvalid && !tready.
- coef_i changed mid-frame (no tuser) → outputs keep the old kernel. The next tuser beat switches the kernel; beats accepted before it are unaffected.
- rst_i asserted with 3 beats in flight → video_o.tvalid = 0 immediately. After release the first output uses the identity kernel.
